ps2_keyboard: RTL and testbench



---
 rtl/hack_io_pkg.sv | 72 +++++++
 rtl/ps2_rx.sv | 81 ++++++++
 rtl/ps2_keyboard.sv | 80 ++++++++
 tb/tb_ps2_keyboard.sv | 137 +++++++++++++
 4 files changed

// File: rtl/hack_io_pkg.sv
// Shared Hack I/O definitions: keyboard codes, PS/2 prefixes, decoder states
// and the scan-code set 2 to Hack keyboard code translation.
package hack_io_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [7:0] KEY_NEWLINE   = 8'd128;
    localparam logic [7:0] KEY_BACKSPACE = 8'd129;
    localparam logic [7:0] KEY_LEFT      = 8'd130;
    localparam logic [7:0] KEY_UP        = 8'd131;
    localparam logic [7:0] KEY_RIGHT     = 8'd132;
    localparam logic [7:0] KEY_DOWN      = 8'd133;
    localparam logic [7:0] KEY_HOME      = 8'd134;
    localparam logic [7:0] KEY_END       = 8'd135;
    localparam logic [7:0] KEY_PGUP      = 8'd136;
    localparam logic [7:0] KEY_PGDN      = 8'd137;
    localparam logic [7:0] KEY_INSERT    = 8'd138;
    localparam logic [7:0] KEY_DELETE    = 8'd139;
    localparam logic [7:0] KEY_ESC       = 8'd140;
    localparam logic [7:0] KEY_F1        = 8'd141;
    localparam logic [7:0] KEY_F12       = 8'd152;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } dec_state_t;

    // Returns 0 for any scan code without a Hack equivalent.
    function automatic logic [7:0] ps2_to_hack(input logic ext, input logic [7:0] code);
        logic [7:0] r;
        r = 8'd0;
        if (ext) begin
            case (code)
                8'h6B: r = KEY_LEFT;    8'h75: r = KEY_UP;
                8'h74: r = KEY_RIGHT;   8'h72: r = KEY_DOWN;
                8'h6C: r = KEY_HOME;    8'h69: r = KEY_END;
                8'h7D: r = KEY_PGUP;    8'h7A: r = KEY_PGDN;
                8'h70: r = KEY_INSERT;  8'h71: r = KEY_DELETE;
                default: r = 8'd0;
            endcase
        end else begin
            case (code)
                8'h1C: r = 8'd65;  8'h32: r = 8'd66;  8'h21: r = 8'd67;  8'h23: r = 8'd68;
                8'h24: r = 8'd69;  8'h2B: r = 8'd70;  8'h34: r = 8'd71;  8'h33: r = 8'd72;
                8'h43: r = 8'd73;  8'h3B: r = 8'd74;  8'h42: r = 8'd75;  8'h4B: r = 8'd76;
                8'h3A: r = 8'd77;  8'h31: r = 8'd78;  8'h44: r = 8'd79;  8'h4D: r = 8'd80;
                8'h15: r = 8'd81;  8'h2D: r = 8'd82;  8'h1B: r = 8'd83;  8'h2C: r = 8'd84;
                8'h3C: r = 8'd85;  8'h2A: r = 8'd86;  8'h1D: r = 8'd87;  8'h22: r = 8'd88;
                8'h35: r = 8'd89;  8'h1A: r = 8'd90;
                8'h45: r = 8'd48;  8'h16: r = 8'd49;  8'h1E: r = 8'd50;  8'h26: r = 8'd51;
                8'h25: r = 8'd52;  8'h2E: r = 8'd53;  8'h36: r = 8'd54;  8'h3D: r = 8'd55;
                8'h3E: r = 8'd56;  8'h46: r = 8'd57;
                8'h29: r = 8'd32;
                8'h5A: r = KEY_NEWLINE;
                8'h66: r = KEY_BACKSPACE;
                8'h76: r = KEY_ESC;
                8'h05: r = KEY_F1;         8'h06: r = 8'(KEY_F1 + 8'd1);
                8'h04: r = 8'(KEY_F1 + 8'd2);  8'h0C: r = 8'(KEY_F1 + 8'd3);
                8'h03: r = 8'(KEY_F1 + 8'd4);  8'h0B: r = 8'(KEY_F1 + 8'd5);
                8'h83: r = 8'(KEY_F1 + 8'd6);  8'h0A: r = 8'(KEY_F1 + 8'd7);
                8'h01: r = 8'(KEY_F1 + 8'd8);  8'h09: r = 8'(KEY_F1 + 8'd9);
                8'h78: r = 8'(KEY_F1 + 8'd10); 8'h07: r = KEY_F12;
                default: r = 8'd0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit frame
// capture with start/parity/stop checks and a mid-frame inactivity timeout.
module ps2_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_err
);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic          r_clk_prev;
    logic [3:0]    r_bit_cnt;
    logic [9:0]    r_shift;
    logic [TW-1:0] r_to_cnt;
    logic [7:0]    r_byte;
    logic          r_valid;
    logic          r_err;
    logic          w_fall;
    logic          w_data;

    assign w_fall = r_clk_prev & ~r_clk_sync[1];
    assign w_data = r_data_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    // Bits shift in from the top so bit k of the frame lands at r_shift[k].
    always_ff @(posedge clk) begin
        r_valid <= 1'b0;
        r_err   <= 1'b0;
        if (reset) begin
            r_bit_cnt <= 4'd0;
            r_shift   <= 10'd0;
            r_to_cnt  <= TW'(0);
            r_byte    <= 8'd0;
        end else if (w_fall) begin
            r_to_cnt <= TW'(0);
            if (r_bit_cnt == 4'd10) begin
                r_bit_cnt <= 4'd0;
                if (!r_shift[0] && (^r_shift[9:1]) && w_data) begin
                    r_byte  <= r_shift[8:1];
                    r_valid <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end else begin
                r_shift   <= {w_data, r_shift[9:1]};
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
        end else if (r_bit_cnt == 4'd0) begin
            r_to_cnt <= TW'(0);
        end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_bit_cnt <= 4'd0;
            r_to_cnt  <= TW'(0);
            r_err     <= 1'b1;
        end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    assign o_byte       = r_byte;
    assign o_byte_valid = r_valid;
    assign o_err        = r_err;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end: prefix-tracking decoder and the Hack keyboard
// register read by the CPU through the memory-mapped keyboard word.
module ps2_keyboard
    import hack_io_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key_code,
    output logic        frame_error
);
    logic [7:0]  w_byte;
    logic        w_valid;
    logic        w_err;
    logic        w_ext;
    logic [7:0]  w_xlat;
    dec_state_t  r_state;
    dec_state_t  w_state_nxt;
    logic [15:0] r_key_code;
    logic [15:0] w_key_nxt;
    logic        r_frame_error;

    ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk          (clk),
        .reset        (reset),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_byte       (w_byte),
        .o_byte_valid (w_valid),
        .o_err        (w_err)
    );

    assign w_ext  = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
    assign w_xlat = ps2_to_hack(w_ext, w_byte);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_key_code    <= 16'd0;
            r_frame_error <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_key_code    <= w_key_nxt;
            r_frame_error <= w_err;
        end
    end

    // A repeated or misplaced prefix resets the decoder and the byte is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key_code;
        if (w_err) begin
            w_state_nxt = ST_IDLE;
        end else if (w_valid) begin
            w_state_nxt = ST_IDLE;
            case (r_state)
                ST_IDLE: begin
                    if (w_byte == PS2_EXT)      w_state_nxt = ST_EXT;
                    else if (w_byte == PS2_BRK) w_state_nxt = ST_BRK;
                    else if (w_xlat != 8'd0)    w_key_nxt = {8'd0, w_xlat};
                end
                ST_EXT: begin
                    if (w_byte == PS2_BRK)                            w_state_nxt = ST_EXT_BRK;
                    else if (w_byte != PS2_EXT && w_xlat != 8'd0)     w_key_nxt = {8'd0, w_xlat};
                end
                default: begin
                    if (w_byte != PS2_EXT && w_byte != PS2_BRK && {8'd0, w_xlat} == r_key_code)
                        w_key_nxt = 16'd0;
                end
            endcase
        end
    end

    assign key_code    = r_key_code;
    assign frame_error = r_frame_error;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: bit-banged PS/2 frames with hand-computed
// Hack codes, exact four-cycle latency, error pulses, timeout and reset.
module tb_ps2_keyboard;
    localparam int unsigned TO = 200;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] key_code;
    logic        frame_error;

    int unsigned n_vec   = 0;
    int unsigned n_miss  = 0;
    logic [15:0] cur_key = 16'd0;
    int          pulses;

    always #5 clk = ~clk;

    ps2_keyboard #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .key_code    (key_code),
        .frame_error (frame_error)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drives the first n bits of a frame; the stop bit gets latency checks.
    task automatic send_bits(input logic [7:0] b, input logic bad_par, input int n,
                             input logic chk, input logic [15:0] exp_key,
                             input logic exp_err, input string tag);
        logic [10:0] f;
        f = {1'b1, (bad_par ? ^b : ~^b), b, 1'b0};
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (5) @(negedge clk);
            ps2_clk = 1'b0;
            if (chk && i == 10) begin
                repeat (3) @(posedge clk);
                #1;
                check_eq({tag, "_pre_key"}, key_code, cur_key);
                check_eq({tag, "_pre_err"}, 16'(frame_error), 16'd0);
                @(posedge clk);
                #1;
                check_eq({tag, "_key"}, key_code, exp_key);
                check_eq({tag, "_err"}, 16'(frame_error), 16'(exp_err));
                @(posedge clk);
                #1;
                check_eq({tag, "_err_end"}, 16'(frame_error), 16'd0);
            end
            repeat (10) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
        if (chk) cur_key = exp_key;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par,
                              input logic [15:0] exp_key, input logic exp_err, input string tag);
        send_bits(b, bad_par, 11, 1'b1, exp_key, exp_err, tag);
    endtask

    task automatic count_pulses(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (frame_error) n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench did not complete");
    end

    initial begin
        repeat (4) @(negedge clk);
        check_eq("rst_key", key_code, 16'd0);
        check_eq("rst_err", 16'(frame_error), 16'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        send_frame(8'h1C, 1'b0, 16'd65, 1'b0, "make_a");
        send_frame(8'hF0, 1'b0, 16'd65, 1'b0, "f0_a");
        send_frame(8'h1C, 1'b0, 16'd0,  1'b0, "brk_a");

        send_frame(8'hE0, 1'b0, 16'd0,   1'b0, "e0_up");
        send_frame(8'h75, 1'b0, 16'd131, 1'b0, "make_up");
        send_frame(8'hF0, 1'b0, 16'd131, 1'b0, "f0_stale");
        send_frame(8'h1C, 1'b0, 16'd131, 1'b0, "brk_stale");
        send_frame(8'hE0, 1'b0, 16'd131, 1'b0, "e0_brk_up");
        send_frame(8'hF0, 1'b0, 16'd131, 1'b0, "f0_brk_up");
        send_frame(8'h75, 1'b0, 16'd0,   1'b0, "brk_up");

        send_frame(8'h29, 1'b1, 16'd0,  1'b1, "par_err");
        send_frame(8'h29, 1'b0, 16'd32, 1'b0, "space");

        send_bits(8'h5A, 1'b0, 5, 1'b0, 16'd0, 1'b0, "partial");
        count_pulses(2 * TO, pulses);
        check_eq("timeout_pulses", 16'(pulses), 16'd1);
        check_eq("timeout_key", key_code, 16'd32);
        send_frame(8'h5A, 1'b0, 16'd128, 1'b0, "enter");

        send_frame(8'h11, 1'b0, 16'd128, 1'b0, "unmapped");
        send_frame(8'h07, 1'b0, 16'd152, 1'b0, "f12");
        send_frame(8'h76, 1'b0, 16'd140, 1'b0, "esc");

        send_bits(8'h16, 1'b0, 6, 1'b0, 16'd0, 1'b0, "partial_rst");
        @(negedge clk);
        reset = 1'b1;
        count_pulses(3, pulses);
        reset = 1'b0;
        begin
            int p2;
            count_pulses(2 * TO, p2);
            pulses += p2;
        end
        check_eq("rst_mid_pulses", 16'(pulses), 16'd0);
        check_eq("rst_mid_key", key_code, 16'd0);
        cur_key = 16'd0;
        send_frame(8'h16, 1'b0, 16'd49, 1'b0, "digit1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
